// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel path:
//   - 640x480@60 timing constants (pulse/porch/active widths and totals)
//   - RGB565 colour constants used by pattern and data generators
//   - counter/address width and the sync bundle carried by the align pipe
// -----------------------------------------------------------------------------
package vga_pkg;

    // Width of the h/v counters and of the pixel addresses.
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned ADDR_MAX = (1 << ADDR_W) - 1;

    // 640x480@60, 25.2 MHz pixel clock.
    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_H_BACK  = 48;
    localparam int unsigned VGA_H_VALID = 640;
    localparam int unsigned VGA_H_FRONT = 16;
    localparam int unsigned VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_VALID + VGA_H_FRONT;

    localparam int unsigned VGA_V_SYNC  = 2;
    localparam int unsigned VGA_V_BACK  = 33;
    localparam int unsigned VGA_V_VALID = 480;
    localparam int unsigned VGA_V_FRONT = 10;
    localparam int unsigned VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_VALID + VGA_V_FRONT;

    // RGB565 colours.
    localparam logic [15:0] BLACK    = 16'h0000;
    localparam logic [15:0] RED      = 16'hF800;
    localparam logic [15:0] GREEN    = 16'h07E0;
    localparam logic [15:0] BLUE     = 16'h001F;
    localparam logic [15:0] YELLOW   = 16'hFFE0;
    localparam logic [15:0] SKY_BLUE = 16'h867D;
    localparam logic [15:0] PURPLE   = 16'hF81F;
    localparam logic [15:0] GRAY     = 16'hD69A;
    localparam logic [15:0] WHITE    = 16'hFFFF;

    // Control bundle that must stay aligned with the pixel data.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    localparam int unsigned SYNC_W = $bits(sync_t);

endpackage

// File: rtl/vga_align_pipe.sv
// -----------------------------------------------------------------------------
// vga_align_pipe
// Fixed-depth shift register that delays the sync/de bundle so it meets the
// pixel data coming back from the data generator. Every stage is exposed so
// the caller can tap an intermediate delay.
//   clk       in   pixel clock
//   rst       in   synchronous active-high reset (loads RST_VAL everywhere)
//   d_i       in   WIDTH-bit word entering the pipe
//   stages_o  out  all stages; stages_o[k] is d_i delayed by k+1 clocks
// -----------------------------------------------------------------------------
module vga_align_pipe #(
    parameter int unsigned      DEPTH   = 2,
    parameter int unsigned      WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            d_i,
    output logic [DEPTH-1:0][WIDTH-1:0] stages_o
);

    if (DEPTH < 2) begin : g_depth_chk
        $error("vga_align_pipe: DEPTH must be at least 2");
    end

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // NOTE: every stage is reset, unlike a RAM array, because a stale stage
    // would leak a partial sync pulse to the pins after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {DEPTH{RST_VAL}};
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], d_i};
        end
    end

    assign stages_o = stage_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
// Free-running h/v counters for the VGA raster. Produces the active-area pixel
// address for the data generator, then re-times sync, blanking and the
// returned pixel so all of them reach the pins on the same clock.
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   data_disp    in   RGB565 pixel, DATA_LAT clocks after its address
//   h_addr       out  active column 0..H_VALID-1, 0 in blanking or reset
//   v_addr       out  active row 0..V_VALID-1, 0 in blanking or reset
//   hsync        out  horizontal sync, level SYNC_POL when asserted
//   vsync        out  vertical sync, level SYNC_POL when asserted
//   vga_de       out  display enable
//   vga_rgb      out  pixel to the DAC, 0 while vga_de is low
//   frame_start  out  one-clock pulse at h_cnt=0, v_cnt=0 (address timing)
// hsync/vsync/vga_de/vga_rgb lag the counters by DATA_LAT+1 clocks.
// -----------------------------------------------------------------------------
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned H_VALID  = VGA_H_VALID,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    parameter int unsigned V_VALID  = VGA_V_VALID,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned DATA_LAT = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       data_disp,
    output logic [ADDR_W-1:0] h_addr,
    output logic [ADDR_W-1:0] v_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              vga_de,
    output logic [15:0]       vga_rgb,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int unsigned DEPTH   = DATA_LAT + 1;

    if (H_TOTAL > ADDR_MAX) begin : g_h_total_chk
        $error("vga_timing_ctrl: H_TOTAL does not fit the 11-bit counter");
    end
    if (V_TOTAL > ADDR_MAX) begin : g_v_total_chk
        $error("vga_timing_ctrl: V_TOTAL does not fit the 11-bit counter");
    end
    if (DATA_LAT < 1 || DATA_LAT > 4) begin : g_lat_chk
        $error("vga_timing_ctrl: DATA_LAT must be 1..4");
    end

    // Region boundaries at counter width; *_END values are exclusive.
    localparam logic [ADDR_W-1:0] H_LAST     = ADDR_W'(H_TOTAL - 1);
    localparam logic [ADDR_W-1:0] V_LAST     = ADDR_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] H_SYNC_END = ADDR_W'(H_SYNC);
    localparam logic [ADDR_W-1:0] V_SYNC_END = ADDR_W'(V_SYNC);
    localparam logic [ADDR_W-1:0] H_ACT_BEG  = ADDR_W'(H_SYNC + H_BACK);
    localparam logic [ADDR_W-1:0] H_ACT_END  = ADDR_W'(H_SYNC + H_BACK + H_VALID);
    localparam logic [ADDR_W-1:0] V_ACT_BEG  = ADDR_W'(V_SYNC + V_BACK);
    localparam logic [ADDR_W-1:0] V_ACT_END  = ADDR_W'(V_SYNC + V_BACK + V_VALID);

    localparam sync_t SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};

    logic [ADDR_W-1:0] h_cnt_q, h_cnt_d;
    logic [ADDR_W-1:0] v_cnt_q, v_cnt_d;
    logic              active;
    sync_t             sync_raw;
    sync_t [DEPTH-1:0] sync_pipe;
    logic [15:0]       vga_rgb_q;

    // ------------------------------------------------------------------ counters
    // NOTE: defaults are assigned before the wrap test so every path drives
    // both next-state values and no latch is inferred.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------- address domain
    assign active = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                    (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);

    // Gated by rst so downstream logic sees a clean 0 from the first reset
    // clock, before the counters have been cleared.
    assign h_addr      = (active && !rst) ? h_cnt_q - H_ACT_BEG : '0;
    assign v_addr      = (active && !rst) ? v_cnt_q - V_ACT_BEG : '0;
    assign frame_start = !rst && (h_cnt_q == '0) && (v_cnt_q == '0);

    assign sync_raw.hsync = (h_cnt_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign sync_raw.vsync = (v_cnt_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign sync_raw.de    = active;

    // ----------------------------------------------------------- pin domain
    vga_align_pipe #(
        .DEPTH   (DEPTH),
        .WIDTH   (SYNC_W),
        .RST_VAL (SYNC_IDLE)
    ) u_align_pipe (
        .clk      (clk),
        .rst      (rst),
        .d_i      (sync_raw),
        .stages_o (sync_pipe)
    );

    // de delayed by DATA_LAT lines up with data_disp; the extra register here
    // matches the final pipe stage so rgb and sync leave together.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_rgb_q <= '0;
        end else begin
            vga_rgb_q <= sync_pipe[DATA_LAT-1].de ? data_disp : '0;
        end
    end

    assign hsync   = sync_pipe[DEPTH-1].hsync;
    assign vsync   = sync_pipe[DEPTH-1].vsync;
    assign vga_de  = sync_pipe[DEPTH-1].de;
    assign vga_rgb = vga_rgb_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_ctrl
// Two instances: the 640x480 default timing with DATA_LAT=1 and active-low
// sync, and a miniature raster with DATA_LAT=3 and active-high sync so that
// many frames and random mid-frame resets fit in a short run. Expected values
// come from a raster model indexed by "clocks since the counters were last
// cleared"; a data generator model returns a salted pixel for each address.
// -----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    typedef struct packed {
        int hs, hb, hv, hf, vs, vb, vv, vf, lat;
        bit pol;
    } tim_t;

    localparam tim_t TA = '{hs: 96, hb: 48, hv: 640, hf: 16,
                            vs: 2, vb: 33, vv: 480, vf: 10, lat: 1, pol: 1'b0};
    localparam tim_t TB = '{hs: 4, hb: 3, hv: 10, hf: 2,
                            vs: 2, vb: 3, vv: 5, vf: 2, lat: 3, pol: 1'b1};

    localparam int NCYC = 36000;   // total simulated clocks
    localparam int P1   = 30000;   // end of the reset-free first phase

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_disp_a, data_disp_b;

    logic [10:0] h_addr_a, v_addr_a, h_addr_b, v_addr_b;
    logic        hsync_a, vsync_a, vga_de_a, frame_start_a;
    logic        hsync_b, vsync_b, vga_de_b, frame_start_b;
    logic [15:0] vga_rgb_a, vga_rgb_b;

    // History, indexed by cycle number.
    bit          rst_h  [NCYC];
    int          pos_h  [NCYC];
    logic [21:0] dut_a_h[NCYC];
    logic [21:0] dut_b_h[NCYC];

    int          cyc = -1;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] salt;

    always #20 clk = ~clk;

    vga_timing_ctrl #(.DATA_LAT(1)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .data_disp   (data_disp_a),
        .h_addr      (h_addr_a),
        .v_addr      (v_addr_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .vga_de      (vga_de_a),
        .vga_rgb     (vga_rgb_a),
        .frame_start (frame_start_a)
    );

    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_VALID(5),  .V_FRONT(2),
        .DATA_LAT(3), .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .data_disp   (data_disp_b),
        .h_addr      (h_addr_b),
        .v_addr      (v_addr_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .vga_de      (vga_de_b),
        .vga_rgb     (vga_rgb_b),
        .frame_start (frame_start_b)
    );

    // ------------------------------------------------------------ raster model
    function automatic int h_tot(tim_t t);
        return t.hs + t.hb + t.hv + t.hf;
    endfunction

    function automatic int frame_len(tim_t t);
        return h_tot(t) * (t.vs + t.vb + t.vv + t.vf);
    endfunction

    function automatic int h_of(tim_t t, int p);
        return (p % frame_len(t)) % h_tot(t);
    endfunction

    function automatic int v_of(tim_t t, int p);
        return (p % frame_len(t)) / h_tot(t);
    endfunction

    function automatic bit is_active(tim_t t, int p);
        int h = h_of(t, p);
        int v = v_of(t, p);
        return h >= t.hs + t.hb && h < t.hs + t.hb + t.hv &&
               v >= t.vs + t.vb && v < t.vs + t.vb + t.vv;
    endfunction

    // {column, row} of an active position, else 0.
    function automatic logic [21:0] addr_of(tim_t t, int p);
        if (!is_active(t, p)) return 22'h0;
        return {11'(h_of(t, p) - t.hs - t.hb), 11'(v_of(t, p) - t.vs - t.vb)};
    endfunction

    function automatic logic [1:0] syncs_of(tim_t t, int p);
        return {(h_of(t, p) < t.hs) ? t.pol : ~t.pol,
                (v_of(t, p) < t.vs) ? t.pol : ~t.pol};
    endfunction

    // Pixel the generator returns for an address: column, low row bits, salt.
    function automatic logic [15:0] pix(logic [21:0] a);
        return {a[4:0], a[21:11]} ^ salt;
    endfunction

    function automatic bit rst_in(int lo, int hi);
        for (int j = lo; j <= hi; j++) begin
            if (j < 0 || rst_h[j]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // {hsync, vsync, de, rgb} at the pins during cycle c: the raster state of
    // cycle c-lat-1, unless a reset edge fell inside that window.
    function automatic logic [18:0] exp_pins(tim_t t, int c);
        int w = c - t.lat - 1;
        if (rst_in(w, c - 1)) return {~t.pol, ~t.pol, 1'b0, 16'h0};
        if (is_active(t, pos_h[w])) return {syncs_of(t, pos_h[w]), 1'b1, pix(addr_of(t, pos_h[w]))};
        return {syncs_of(t, pos_h[w]), 1'b0, 16'h0};
    endfunction

    // Data generator: the pixel for the address seen lat clocks ago, or noise
    // when that address was not a displayed pixel.
    function automatic logic [15:0] gen(tim_t t, int c, logic [21:0] seen);
        int s = c - t.lat;
        if (s >= 0 && !rst_h[s] && is_active(t, pos_h[s])) return pix(seen);
        return 16'($urandom);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int pos   = 0;
        int gap   = 0;
        int burst = 0;
        rst         = 1'b1;
        data_disp_a = '0;
        data_disp_b = '0;
        salt        = 16'($urandom);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            // rst still holds the value the DUT sampled on this edge.
            pos      = rst ? 0 : pos + 1;
            pos_h[c] = pos;
            #1;
            if (c < 5) begin
                rst = 1'b1;
            end else if (c < P1) begin
                rst = 1'b0;
            end else if (burst > 0) begin
                rst = 1'b1;
                burst--;
            end else if (gap > 0) begin
                rst = 1'b0;
                gap--;
            end else begin
                rst   = 1'b1;
                burst = $urandom_range(5, 0);
                gap   = $urandom_range(700, 40);
            end
            rst_h[c]    = rst;
            data_disp_a = gen(TA, c, (c >= TA.lat) ? dut_a_h[c - TA.lat] : 22'h0);
            data_disp_b = gen(TB, c, (c >= TB.lat) ? dut_b_h[c - TB.lat] : 22'h0);
            cyc         = c;
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ----------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (cyc >= 0) begin
            automatic int c = cyc;
            automatic int p = pos_h[c];
            automatic bit r = rst_h[c];

            check("A pins", {13'h0, hsync_a, vsync_a, vga_de_a, vga_rgb_a}, {13'h0, exp_pins(TA, c)});
            check("A addr", {10'h0, h_addr_a, v_addr_a}, {10'h0, r ? 22'h0 : addr_of(TA, p)});
            check("A frame_start", {31'h0, frame_start_a}, {31'h0, !r && (p % frame_len(TA) == 0)});
            check("B pins", {13'h0, hsync_b, vsync_b, vga_de_b, vga_rgb_b}, {13'h0, exp_pins(TB, c)});
            check("B addr", {10'h0, h_addr_b, v_addr_b}, {10'h0, r ? 22'h0 : addr_of(TB, p)});
            check("B frame_start", {31'h0, frame_start_b}, {31'h0, !r && (p % frame_len(TB) == 0)});
            dut_a_h[c] = {h_addr_a, v_addr_a};
            dut_b_h[c] = {h_addr_b, v_addr_b};

            // Hand-computed anchor points for the model.
            if (!r) begin
                if (p == 0) check("A lit frame_start at 0", {31'h0, frame_start_a}, 32'd1);
                if (p == 1) check("A lit hsync idle at 1", {31'h0, hsync_a}, 32'd1);
                if (p == 2) check("A lit hsync low at 2", {31'h0, hsync_a}, 32'd0);
                if (p == 97) check("A lit hsync low at 97", {31'h0, hsync_a}, 32'd0);
                if (p == 98) check("A lit hsync high at 98", {31'h0, hsync_a}, 32'd1);
                if (p == 34 * 800 + 400) check("A lit addr line 34", {10'h0, h_addr_a, v_addr_a}, 32'd0);
                if (p == 35 * 800 + 143) check("A lit addr h143", {10'h0, h_addr_a, v_addr_a}, 32'd0);
                if (p == 35 * 800 + 145) check("A lit h_addr 1", {21'h0, h_addr_a}, 32'd1);
                if (p == 35 * 800 + 783) check("A lit h_addr 639", {21'h0, h_addr_a}, 32'd639);
                if (p == 35 * 800 + 784) check("A lit addr h784", {10'h0, h_addr_a, v_addr_a}, 32'd0);
                if (p == 36 * 800 + 144) check("A lit v_addr 1", {21'h0, v_addr_a}, 32'd1);
                if (p == 35 * 800 + 147) check("A lit rgb col 1", {16'h0, vga_rgb_a}, {16'h0, salt ^ 16'd1});
                if (p == 3) check("B lit hsync idle at 3", {31'h0, hsync_b}, 32'd0);
                if (p == 4) check("B lit hsync high at 4", {31'h0, hsync_b}, 32'd1);
                if (p == 7) check("B lit hsync high at 7", {31'h0, hsync_b}, 32'd1);
                if (p == 8) check("B lit hsync low at 8", {31'h0, hsync_b}, 32'd0);
                if (p == 105) check("B lit de low at 105", {31'h0, vga_de_b}, 32'd0);
                if (p == 106) check("B lit de high at 106", {31'h0, vga_de_b}, 32'd1);
            end
        end
    end

endmodule
